// File: rtl/mha_pkg.sv
// Shared widths and drain FSM state for the MHA accumulator drain stage.
package mha_pkg;
  localparam int ACC_WIDTH       = 8;
  localparam int SYSTOLIC_COLUMN = 16;
  localparam int PE_BLK_COUNT    = 16;
  localparam int FIFO_DEPTH      = 4;
  localparam int TILE_ROWS       = 16;

  localparam int BLK_W     = ACC_WIDTH * SYSTOLIC_COLUMN;
  localparam int ROW_W     = BLK_W * PE_BLK_COUNT;
  localparam int BLK_IDX_W = $clog2(PE_BLK_COUNT);
  localparam int ROW_IDX_W = $clog2(TILE_ROWS);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int DLY       = SYSTOLIC_COLUMN - 1;
  localparam int ENTRY_W   = ROW_W + ROW_IDX_W;

  typedef enum logic {IDLE, SEND} drain_state_e;
endpackage

// File: rtl/mha_acc_drain_if.sv
// Serialised PE-block beat stream from the drain stage towards writeback/softmax.
interface mha_acc_drain_if;
  import mha_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [BLK_W-1:0]     out_data;
  logic [BLK_IDX_W-1:0] out_blk_idx;
  logic [ROW_IDX_W-1:0] out_row_idx;
  logic                 out_last;

  modport master (output out_valid, out_data, out_blk_idx, out_row_idx, out_last,
                  input  out_ready);
  modport slave  (input  out_valid, out_data, out_blk_idx, out_row_idx, out_last,
                  output out_ready);
endinterface

// File: rtl/mha_row_fifo.sv
// Synchronous row FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module mha_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             wr_en, rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Head is read combinationally so the drain sees the entry the cycle after it is written.
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
    end
  end
endmodule

// File: rtl/mha_acc_drain.sv
// Re-times the deskewed row strobe, buffers whole accumulator rows and streams them
// out one PE block per beat; rows arriving with the buffer full are dropped and flagged.
module mha_acc_drain
  import mha_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_valid_in,
  input  logic [ROW_W-1:0]     acc_stage,
  mha_acc_drain_if.master      out_if,
  output logic                 overflow,
  output logic [CNT_W-1:0]     fifo_count
);
  logic [DLY-1:0]       dly_q, dly_d;
  logic [ROW_IDX_W-1:0] row_cnt_q, row_cnt_d;
  logic                 overflow_q, overflow_d;
  drain_state_e         state_q, state_d;
  logic [BLK_IDX_W-1:0] blk_q, blk_d;
  logic                 cap, send, beat, last_blk;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   head;
  logic [ROW_W-1:0]     head_data;
  logic [ROW_IDX_W-1:0] head_row;
  logic [BLK_W-1:0]     head_blk [PE_BLK_COUNT];

  assign cap       = dly_q[DLY-1];
  assign send      = (state_q == SEND);
  assign beat      = send && out_if.out_ready;
  assign last_blk  = (blk_q == BLK_IDX_W'(PE_BLK_COUNT-1));
  assign fifo_pop  = beat && last_blk;
  // A full buffer still takes the row if its head leaves on this very edge.
  assign fifo_push = cap && (!fifo_full || fifo_pop);

  mha_row_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({acc_stage, row_cnt_q}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_row  = head[ROW_IDX_W-1:0];
  assign head_data = head[ENTRY_W-1:ROW_IDX_W];

  generate
    for (genvar gi = 0; gi < PE_BLK_COUNT; gi++) begin : g_slice
      assign head_blk[gi] = head_data[gi*BLK_W +: BLK_W];
    end
  endgenerate

  always_comb begin
    dly_d     = {dly_q[DLY-2:0], acc_valid_in};
    row_cnt_d = row_cnt_q;
    // Row numbering follows array rows, so dropped rows still consume an index.
    if (cap) row_cnt_d = (row_cnt_q == ROW_IDX_W'(TILE_ROWS-1)) ? '0 : row_cnt_q + ROW_IDX_W'(1);
    overflow_d = overflow_q | (cap & ~fifo_push);
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: if (fifo_push || !fifo_empty) state_d = SEND;
      SEND: begin
        if (beat) begin
          if (last_blk) begin
            blk_d = '0;
            if (!fifo_push && fifo_count <= CNT_W'(1)) state_d = IDLE;
          end else begin
            blk_d = blk_q + BLK_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q      <= '0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      blk_q      <= '0;
    end else begin
      dly_q      <= dly_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      blk_q      <= blk_d;
    end
  end

  assign out_if.out_valid   = send;
  assign out_if.out_data    = send ? head_blk[blk_q] : '0;
  assign out_if.out_blk_idx = blk_q;
  assign out_if.out_row_idx = send ? head_row : '0;
  assign out_if.out_last    = send && last_blk && (head_row == ROW_IDX_W'(TILE_ROWS-1));
  assign overflow           = overflow_q;
endmodule

// File: tb/tb_mha_acc_drain.sv
// Randomised scoreboard bench for mha_acc_drain against a row-level queue model.
`timescale 1ns/1ps
module tb_mha_acc_drain;
  import mha_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             acc_valid_in = 1'b0;
  logic [ROW_W-1:0] acc_stage = '0;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  mha_acc_drain_if out_if();

  mha_acc_drain dut (
    .clk          (clk),
    .reset        (reset),
    .acc_valid_in (acc_valid_in),
    .acc_stage    (acc_stage),
    .out_if       (out_if),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  typedef struct {
    logic [BLK_W-1:0] data;
    int               blk;
    int               row;
    bit               last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    vq[$];       // cycle numbers of accepted-in-flight valids
  int    mq[$];       // row indices held in the modelled buffer
  int    cyc = 0, mbeat = 0, mrow = 0;
  bit    movf = 1'b0;
  bit    m_beat, m_fin, m_cap;
  int    n_pass = 0, n_total = 0, hs_cnt = 0, last_cnt = 0;
  bit    mon_en = 1'b0, rnd_stage = 1'b1;

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference model: row-level view of capture, buffering and per-beat draining.
  always @(posedge clk) begin
    if (reset) begin
      vq.delete(); mq.delete(); exp_q.delete();
      mbeat = 0; mrow = 0; movf = 1'b0;
    end else begin
      m_beat = (mq.size() != 0) && out_if.out_ready;
      m_fin  = m_beat && (mbeat == PE_BLK_COUNT-1);
      m_cap  = (vq.size() != 0) && (vq[0] == cyc - DLY);
      if (m_cap) void'(vq.pop_front());
      if (m_beat) begin
        mbeat++;
        if (m_fin) begin
          mbeat = 0;
          void'(mq.pop_front());
        end
      end
      if (m_cap) begin
        if (mq.size() < FIFO_DEPTH) begin
          mq.push_back(mrow);
          for (int b = 0; b < PE_BLK_COUNT; b++)
            exp_q.push_back('{acc_stage[b*BLK_W +: BLK_W], b, mrow,
                              (b == PE_BLK_COUNT-1) && (mrow == TILE_ROWS-1)});
        end else begin
          movf = 1'b1;
        end
        mrow = (mrow + 1) % TILE_ROWS;
      end
      if (acc_valid_in) vq.push_back(cyc);
    end
    cyc++;
  end

  // Monitor: compares every handshake against the scoreboard and tracks stalls.
  logic [BLK_W-1:0]     p_data;
  logic [BLK_IDX_W-1:0] p_blk;
  logic [ROW_IDX_W-1:0] p_row;
  logic                 p_last;
  bit                   p_stall = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("valid", BLK_W'(out_if.out_valid), BLK_W'(mq.size() != 0));
      chk("count", BLK_W'(fifo_count), BLK_W'(mq.size()));
      chk("overflow", BLK_W'(overflow), BLK_W'(movf));
      if (p_stall) begin
        chk("hold_valid", BLK_W'(out_if.out_valid), BLK_W'(1));
        chk("hold_data", out_if.out_data, p_data);
        chk("hold_blk", BLK_W'(out_if.out_blk_idx), BLK_W'(p_blk));
        chk("hold_row", BLK_W'(out_if.out_row_idx), BLK_W'(p_row));
        chk("hold_last", BLK_W'(out_if.out_last), BLK_W'(p_last));
      end
      if (out_if.out_valid && out_if.out_ready) begin
        hs_cnt++;
        if (out_if.out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", BLK_W'(1), BLK_W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_if.out_data, e.data);
          chk("beat_blk", BLK_W'(out_if.out_blk_idx), BLK_W'(e.blk));
          chk("beat_row", BLK_W'(out_if.out_row_idx), BLK_W'(e.row));
          chk("beat_last", BLK_W'(out_if.out_last), BLK_W'(e.last));
        end
      end
      p_stall = out_if.out_valid && !out_if.out_ready;
      p_data  = out_if.out_data;
      p_blk   = out_if.out_blk_idx;
      p_row   = out_if.out_row_idx;
      p_last  = out_if.out_last;
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_stage)
      for (int w = 0; w < ROW_W/32; w++) acc_stage[w*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_valid(input int n);
    acc_valid_in = 1'b1;
    repeat (n) tick();
    acc_valid_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, BLK_W'(out_if.out_valid), '0);
    chk({tag, "_data"}, out_if.out_data, '0);
    chk({tag, "_blk"}, BLK_W'(out_if.out_blk_idx), '0);
    chk({tag, "_row"}, BLK_W'(out_if.out_row_idx), '0);
    chk({tag, "_last"}, BLK_W'(out_if.out_last), '0);
    chk({tag, "_ovf"}, BLK_W'(overflow), '0);
    chk({tag, "_cnt"}, BLK_W'(fifo_count), '0);
  endtask

  task automatic drain();
    out_if.out_ready = 1'b1;
    repeat (DLY + 2) tick();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    tick();
    chk("drain_idle", BLK_W'(out_if.out_valid), '0);
    chk("drain_cnt", BLK_W'(fifo_count), '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int h0;
    logic [BLK_W-1:0] blk0;
    out_if.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    chk_reset_outputs("rst");

    // Single row with element(b,c) = 16b+c, checking capture latency.
    rnd_stage = 1'b0;
    for (int b = 0; b < PE_BLK_COUNT; b++)
      for (int c = 0; c < SYSTOLIC_COLUMN; c++)
        acc_stage[(b*SYSTOLIC_COLUMN + c)*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(SYSTOLIC_COLUMN*b + c);
    for (int c = 0; c < SYSTOLIC_COLUMN; c++) blk0[c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(c);
    out_if.out_ready = 1'b1;
    h0 = hs_cnt;
    pulse_valid(1);
    repeat (14) tick();
    chk("lat_pre", BLK_W'(out_if.out_valid), '0);
    tick();
    chk("lat_valid", BLK_W'(out_if.out_valid), BLK_W'(1));
    chk("lat_blk0", BLK_W'(out_if.out_blk_idx), '0);
    chk("lat_data0", out_if.out_data, blk0);
    drain();
    chk("row1_beats", BLK_W'(hs_cnt - h0), BLK_W'(16));
    rnd_stage = 1'b1;

    // Backpressure for 5 cycles mid-row.
    h0 = hs_cnt;
    pulse_valid(1);
    repeat (18) tick();
    out_if.out_ready = 1'b0;
    repeat (5) tick();
    drain();
    chk("bp_beats", BLK_W'(hs_cnt - h0), BLK_W'(16));

    // Full buffer with the head's final beat coinciding with a capture.
    out_if.out_ready = 1'b0;
    pulse_valid(4);
    repeat (20) tick();
    chk("full_cnt", BLK_W'(fifo_count), BLK_W'(4));
    out_if.out_ready = 1'b1;
    pulse_valid(1);
    repeat (15) tick();
    chk("fullpop_cnt", BLK_W'(fifo_count), BLK_W'(4));
    chk("fullpop_ovf", BLK_W'(overflow), '0);
    drain();

    // Overflow: five back-to-back rows with no draining.
    do_reset();
    out_if.out_ready = 1'b0;
    h0 = hs_cnt;
    pulse_valid(5);
    repeat (25) tick();
    chk("ovf_cnt", BLK_W'(fifo_count), BLK_W'(4));
    chk("ovf_flag", BLK_W'(overflow), BLK_W'(1));
    drain();
    chk("ovf_beats", BLK_W'(hs_cnt - h0), BLK_W'(64));
    pulse_valid(1);
    repeat (15) tick();
    chk("ovf_next_valid", BLK_W'(out_if.out_valid), BLK_W'(1));
    chk("ovf_next_row", BLK_W'(out_if.out_row_idx), BLK_W'(5));
    drain();

    // Reset during beat 7 of row 0 with two rows still buffered.
    out_if.out_ready = 1'b1;
    pulse_valid(3);
    repeat (20) tick();
    chk("mid_blk7", BLK_W'(out_if.out_blk_idx), BLK_W'(7));
    do_reset();
    chk_reset_outputs("midrst");
    pulse_valid(1);
    repeat (14) tick();
    chk("midrst_pre", BLK_W'(out_if.out_valid), '0);
    tick();
    chk("midrst_valid", BLK_W'(out_if.out_valid), BLK_W'(1));
    chk("midrst_row", BLK_W'(out_if.out_row_idx), '0);
    drain();

    // Tile wrap: 17 rows spaced 16 cycles apart.
    do_reset();
    h0 = last_cnt;
    out_if.out_ready = 1'b1;
    for (int r = 0; r < 17; r++) begin
      pulse_valid(1);
      repeat (15) tick();
    end
    drain();
    chk("wrap_last_count", BLK_W'(last_cnt - h0), BLK_W'(1));

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      acc_valid_in     = ($urandom_range(0, 5) == 0);
      out_if.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    acc_valid_in = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
